// File: rtl/alu_exec_stage_if.sv
// Handshake bundle for the ALU execute stage: operation/operand request side and
// result/flag response side, plus the accepted-operation counter.
interface alu_exec_stage_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       Operation;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] ALUResult;
  logic             Zero;
  logic             Overflow;
  logic             Illegal;
  logic [CNT_W-1:0] op_count;

  // Producer of operations and consumer of results.
  modport master (
    output in_valid, Operation, A, B, out_ready,
    input  in_ready, out_valid, ALUResult, Zero, Overflow, Illegal, op_count
  );

  // The execute stage itself.
  modport slave (
    input  in_valid, Operation, A, B, out_ready,
    output in_ready, out_valid, ALUResult, Zero, Overflow, Illegal, op_count
  );
endinterface

// File: rtl/alu_exec_stage.sv
// Registered ALU execute stage with a main + skid output buffer, so in_ready comes
// from a flop and the stage still sustains one operation per cycle under back-pressure.
module alu_exec_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  alu_exec_stage_if.slave     bus
);

  localparam int unsigned MSB = WIDTH - 1;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_XOR = 4'b1100;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
    logic             illegal;
  } res_t;

  // Encoding chosen so bit 0 is the main-register valid and bit 1 the skid valid.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_e;

  state_e           state_q;
  res_t             main_q;
  res_t             skid_q;
  logic             in_ready_q;
  logic [CNT_W-1:0] op_count_q;

  res_t             alu_d;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             accept;
  logic             drain;

  assign sum  = bus.A + bus.B;
  assign diff = bus.A - bus.B;

  // Combinational ALU evaluated on the presented operands.
  always_comb begin
    alu_d = '0;
    unique case (bus.Operation)
      OP_AND: alu_d.result = bus.A & bus.B;
      OP_OR:  alu_d.result = bus.A | bus.B;
      OP_XOR: alu_d.result = bus.A ^ bus.B;
      OP_ADD: begin
        alu_d.result   = sum;
        alu_d.overflow = (bus.A[MSB] == bus.B[MSB]) && (sum[MSB] != bus.A[MSB]);
      end
      OP_SUB: begin
        alu_d.result   = diff;
        alu_d.overflow = (bus.A[MSB] != bus.B[MSB]) && (diff[MSB] != bus.A[MSB]);
      end
      OP_SLT: alu_d.result = WIDTH'($signed(bus.A) < $signed(bus.B));
      default: alu_d.illegal = 1'b1;
    endcase
    alu_d.zero = (alu_d.result == '0);
  end

  assign accept = bus.in_valid & bus.in_ready;
  assign drain  = bus.out_valid & bus.out_ready;

  // Reset gating keeps in_ready low during reset while the flop already holds 1,
  // so the stage accepts in the very first cycle after reset releases.
  assign bus.in_ready  = in_ready_q & ~reset;
  assign bus.out_valid = state_q[0];
  assign bus.ALUResult = main_q.result;
  assign bus.Zero      = main_q.zero;
  assign bus.Overflow  = main_q.overflow;
  assign bus.Illegal   = main_q.illegal;
  assign bus.op_count  = op_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
      op_count_q <= '0;
    end else begin
      if (accept && (op_count_q != '1)) begin
        op_count_q <= op_count_q + CNT_W'(1);
      end
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            main_q  <= alu_d;
            state_q <= ONE;
          end
        end
        ONE: begin
          unique case ({accept, drain})
            2'b11: main_q <= alu_d;
            2'b10: begin
              skid_q     <= alu_d;
              state_q    <= FULL;
              in_ready_q <= 1'b0;
            end
            2'b01: state_q <= EMPTY;
            default: ;
          endcase
        end
        FULL: begin
          if (drain) begin
            main_q     <= skid_q;
            state_q    <= ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= EMPTY;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule
